big_core_kbd_ascii_decoder: RTL
===============================

# big_core_kbd_ascii_decoder

Downstream of `big_core_kdb_controller`: consumes its validated PS/2 Set-2 scancode bytes, tracks the make/break/extended prefix sequence and the shift/caps-lock modifier state, and translates key presses into 7-bit ASCII. Characters are buffered in a small show-ahead FIFO that the core drains through a read-enable handshake. All logic runs in the core clock domain.

## Interface
- `FIFO_DEPTH`, default 8: character buffer depth; power of 2, minimum 2.
- `core_clk`  in  1  core clock; all logic on the rising edge.
- `core_rst`  in  1  asynchronous, active-high reset.
- `kc_valid`  in  1  one-cycle pulse from the controller: `kc_data` holds a new byte.
- `kc_data`  in  8  scancode byte; sampled only when `kc_valid` is high.
- `kc_error`  in  1  controller parity/framing error, one-cycle pulse.
- `rd_en`  in  1  core pops the FIFO head; ignored when `rd_valid` is low.
- `clr_err`  in  1  clears both sticky error flags.
- `rd_data`  out  8  FIFO head as {1'b0, ascii[6:0]}; 0x00 when empty.
- `rd_valid`  out  1  FIFO not empty.
- `overflow`  out  1  sticky: a character was dropped because the FIFO was full.
- `kbd_err`  out  1  sticky: `kc_error` was seen.
- `shift_st`, `caps_st`  out  1 each  current modifier state.

## Operation
- Prefix FSM states: `IDLE`, `BRK` (after F0), `EXT` (after E0), `EXT_BRK` (after E0 F0).
  - `IDLE`: F0 -> `BRK`; E0 -> `EXT`; any other byte is a make code; stay in `IDLE`.
  - `BRK`: byte is a break code -> `IDLE`.
  - `EXT`: F0 -> `EXT_BRK`; any other byte -> `IDLE`.
  - `EXT_BRK`: any byte -> `IDLE`.
  - Extended keys never produce characters or change modifiers.
- Modifiers:
  - Make 0x12 or 0x59 sets `lshift` or `rshift`; the matching break clears it. `shift_st` = `lshift | rshift`.
  - Make 0x58 toggles `caps_st`; its break is ignored, and typematic repeats of 0x58 toggle again.
- Translation applies to make codes in `IDLE` only:
  - Letters: A=1C B=32 C=21 D=23 E=24 F=2B G=34 H=33 I=43 J=3B K=42 L=4B M=3A N=31 O=44 P=4D Q=15 R=2D S=1B T=2C U=3C V=2A W=1D X=22 Y=35 Z=1A.
    - Uppercase when `shift_st ^ caps_st`, otherwise lowercase.
  - Digits 1..0 = 16 1E 26 25 2E 36 3D 3E 46 45.
    - With shift they map to `!@#$%^&*()`; caps lock has no effect.
  - Space 29 -> 0x20, Enter 5A -> 0x0D, Backspace 66 -> 0x08.
  - Every other code is dropped silently.
- FIFO:
  - A push with FIFO full and no pop in the same cycle drops the character and sets `overflow`.
  - A push and a pop in the same cycle are both honoured, including when full.
- Error:
  - `kc_error` returns the FSM to `IDLE` and sets `kbd_err`. Modifiers and FIFO are untouched.
  - If `kc_error` and `kc_valid` arrive in the same cycle, the byte is discarded.
- `clr_err` clears the sticky flags. If it coincides with a new error event, set wins.

## Timing
- Reset: FSM `IDLE`; modifiers, `overflow`, `kbd_err`, `rd_valid` = 0; FIFO pointers = 0; `rd_data` = 0x00.
- Stage 1: `kc_valid` sampled at edge N updates FSM and modifiers at N and registers {char, push}.
- Stage 2: FIFO write at edge N+1; `rd_valid`/`rd_data` reflect it after N+1.
  - Latency is 2 edges, sampling edge to `rd_valid`.
- Modifier updates at edge N apply to a byte sampled at N+1.
  - Back-to-back `kc_valid` pulses are accepted every cycle.
- Pop: `rd_en` at edge M advances the head. Next entry, or `rd_valid` = 0, is visible after M.
- Asserting `core_rst` mid-sequence immediately clears all state. Pending stage-1 data is lost.

## Structure
- `big_core_pkg` gets:
  - `t_kbd_prefix_st` enum;
  - localparams for the prefix codes E0/F0;
  - localparams for the modifier scancodes 12/59/58.
- The scancode -> ASCII lookup is a combinational function in this module, taking (code, upper) and returning {hit, ascii}.
- Sub-module `big_core_kbd_fifo`:
  - parameterised sync FIFO, show-ahead;
  - count width `$clog2(FIFO_DEPTH)+1`;
  - outputs `full`/`empty`.

## Test plan
- Press/release: 1D, F0 1D -> one entry 0x77 (`w`); `rd_en` -> `rd_valid` low; break produces nothing.
- Modifiers: 12, 1D, F0 12, 1D -> 0x57 then 0x77.
- Caps and digits:
  - 58, F0 58, 1D, 16 -> 0x57, 0x31;
  - then 59, 1D -> 0x77 (shift^caps);
  - then 16 -> 0x21.
- Extended: E0 75, E0 F0 75, then 1C -> only 0x61; FSM back in `IDLE`.
- Overflow: 9 make codes of 29 with no reads -> 8 × 0x20, `overflow`=1.
  - Simultaneous push+pop while full keeps the count at 8.
  - `clr_err` clears the flag.
- Error/reset:
  - F0 then `kc_error`, then 1C -> 0x61 emitted and `kbd_err`=1.
  - `core_rst` asserted mid `EXT_BRK` -> all outputs at reset values.

Source files
------------

// File: rtl/big_core_pkg.sv
// rtl/big_core_pkg.sv - shared types and scancode constants for the keyboard path
package big_core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } t_kbd_prefix_st;

  localparam logic [7:0] KBD_PFX_EXT   = 8'hE0;
  localparam logic [7:0] KBD_PFX_BRK   = 8'hF0;
  localparam logic [7:0] KBD_SC_LSHIFT = 8'h12;
  localparam logic [7:0] KBD_SC_RSHIFT = 8'h59;
  localparam logic [7:0] KBD_SC_CAPS   = 8'h58;

  function automatic logic kbd_is_lower(input logic [6:0] c);
    return (c >= 7'h61) && (c <= 7'h7A);
  endfunction

endpackage

// File: rtl/big_core_kbd_ascii_decoder_if.sv
// rtl/big_core_kbd_ascii_decoder_if.sv - scancode input, character read port and status of the decoder
interface big_core_kbd_ascii_decoder_if;
  logic       kc_valid;
  logic [7:0] kc_data;
  logic       kc_error;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       overflow;
  logic       kbd_err;
  logic       shift_st;
  logic       caps_st;

  modport master (
    output kc_valid, kc_data, kc_error, rd_en, clr_err,
    input  rd_data, rd_valid, overflow, kbd_err, shift_st, caps_st
  );

  modport slave (
    input  kc_valid, kc_data, kc_error, rd_en, clr_err,
    output rd_data, rd_valid, overflow, kbd_err, shift_st, caps_st
  );
endinterface

// File: rtl/big_core_kbd_fifo.sv
// rtl/big_core_kbd_fifo.sv - show-ahead synchronous FIFO; head is valid whenever not empty
module big_core_kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop;
  logic             push;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = rd_en & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push  = wr_en & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/big_core_kbd_ascii_decoder.sv
// rtl/big_core_kbd_ascii_decoder.sv - Set-2 scancode to ASCII translation with prefix/modifier tracking
module big_core_kbd_ascii_decoder
  import big_core_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input logic                         core_clk,
  input logic                         core_rst,
  big_core_kbd_ascii_decoder_if.slave bus
);

  // Returns {hit, ascii}; upper selects the shifted form of the key.
  function automatic logic [7:0] kbd_lookup(input logic [7:0] code, input logic upper);
    logic       hit;
    logic [6:0] lo;
    logic [6:0] hi;
    hit = 1'b1;
    lo  = 7'h00;
    hi  = 7'h00;
    case (code)
      8'h1C: begin lo = 7'h61; hi = 7'h41; end
      8'h32: begin lo = 7'h62; hi = 7'h42; end
      8'h21: begin lo = 7'h63; hi = 7'h43; end
      8'h23: begin lo = 7'h64; hi = 7'h44; end
      8'h24: begin lo = 7'h65; hi = 7'h45; end
      8'h2B: begin lo = 7'h66; hi = 7'h46; end
      8'h34: begin lo = 7'h67; hi = 7'h47; end
      8'h33: begin lo = 7'h68; hi = 7'h48; end
      8'h43: begin lo = 7'h69; hi = 7'h49; end
      8'h3B: begin lo = 7'h6A; hi = 7'h4A; end
      8'h42: begin lo = 7'h6B; hi = 7'h4B; end
      8'h4B: begin lo = 7'h6C; hi = 7'h4C; end
      8'h3A: begin lo = 7'h6D; hi = 7'h4D; end
      8'h31: begin lo = 7'h6E; hi = 7'h4E; end
      8'h44: begin lo = 7'h6F; hi = 7'h4F; end
      8'h4D: begin lo = 7'h70; hi = 7'h50; end
      8'h15: begin lo = 7'h71; hi = 7'h51; end
      8'h2D: begin lo = 7'h72; hi = 7'h52; end
      8'h1B: begin lo = 7'h73; hi = 7'h53; end
      8'h2C: begin lo = 7'h74; hi = 7'h54; end
      8'h3C: begin lo = 7'h75; hi = 7'h55; end
      8'h2A: begin lo = 7'h76; hi = 7'h56; end
      8'h1D: begin lo = 7'h77; hi = 7'h57; end
      8'h22: begin lo = 7'h78; hi = 7'h58; end
      8'h35: begin lo = 7'h79; hi = 7'h59; end
      8'h1A: begin lo = 7'h7A; hi = 7'h5A; end
      8'h16: begin lo = 7'h31; hi = 7'h21; end
      8'h1E: begin lo = 7'h32; hi = 7'h40; end
      8'h26: begin lo = 7'h33; hi = 7'h23; end
      8'h25: begin lo = 7'h34; hi = 7'h24; end
      8'h2E: begin lo = 7'h35; hi = 7'h25; end
      8'h36: begin lo = 7'h36; hi = 7'h5E; end
      8'h3D: begin lo = 7'h37; hi = 7'h26; end
      8'h3E: begin lo = 7'h38; hi = 7'h2A; end
      8'h46: begin lo = 7'h39; hi = 7'h28; end
      8'h45: begin lo = 7'h30; hi = 7'h29; end
      8'h29: begin lo = 7'h20; hi = 7'h20; end
      8'h5A: begin lo = 7'h0D; hi = 7'h0D; end
      8'h66: begin lo = 7'h08; hi = 7'h08; end
      default: hit = 1'b0;
    endcase
    return {hit, upper ? hi : lo};
  endfunction

  t_kbd_prefix_st st, st_nxt;
  logic       lshift, lshift_nxt;
  logic       rshift, rshift_nxt;
  logic       caps, caps_nxt;
  logic       push_q, push_nxt;
  logic [6:0] ch_q, ch_nxt;
  logic       shift;
  logic [7:0] lo_res;
  logic       letter;
  logic [7:0] xl;
  logic       fifo_full;
  logic       fifo_empty;
  logic [6:0] fifo_dout;
  logic       ovf_evt;
  logic       kerr_q;
  logic       ovf_q;

  assign shift  = lshift | rshift;
  // Caps lock only flips letters; digits and symbols follow shift alone.
  assign lo_res = kbd_lookup(bus.kc_data, 1'b0);
  assign letter = lo_res[7] & kbd_is_lower(lo_res[6:0]);
  assign xl     = kbd_lookup(bus.kc_data, letter ? (shift ^ caps) : shift);

  always_comb begin
    st_nxt     = st;
    lshift_nxt = lshift;
    rshift_nxt = rshift;
    caps_nxt   = caps;
    push_nxt   = 1'b0;
    ch_nxt     = 7'h00;
    if (bus.kc_error) begin
      st_nxt = IDLE;
    end else if (bus.kc_valid) begin
      unique case (st)
        IDLE: begin
          if (bus.kc_data == KBD_PFX_BRK)        st_nxt = BRK;
          else if (bus.kc_data == KBD_PFX_EXT)   st_nxt = EXT;
          else if (bus.kc_data == KBD_SC_LSHIFT) lshift_nxt = 1'b1;
          else if (bus.kc_data == KBD_SC_RSHIFT) rshift_nxt = 1'b1;
          else if (bus.kc_data == KBD_SC_CAPS)   caps_nxt = ~caps;
          else begin
            push_nxt = xl[7];
            ch_nxt   = xl[6:0];
          end
        end
        BRK: begin
          st_nxt = IDLE;
          if (bus.kc_data == KBD_SC_LSHIFT) lshift_nxt = 1'b0;
          if (bus.kc_data == KBD_SC_RSHIFT) rshift_nxt = 1'b0;
        end
        EXT:     st_nxt = (bus.kc_data == KBD_PFX_BRK) ? EXT_BRK : IDLE;
        EXT_BRK: st_nxt = IDLE;
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      st     <= IDLE;
      lshift <= 1'b0;
      rshift <= 1'b0;
      caps   <= 1'b0;
      push_q <= 1'b0;
      ch_q   <= 7'h00;
    end else begin
      st     <= st_nxt;
      lshift <= lshift_nxt;
      rshift <= rshift_nxt;
      caps   <= caps_nxt;
      push_q <= push_nxt;
      ch_q   <= ch_nxt;
    end
  end

  big_core_kbd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (7)
  ) u_fifo (
    .clk     (core_clk),
    .rst     (core_rst),
    .wr_en   (push_q),
    .wr_data (ch_q),
    .rd_en   (bus.rd_en),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ovf_evt = push_q & fifo_full & ~bus.rd_en;

  // Set beats clear when an event lands in the same cycle as clr_err.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      kerr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (bus.kc_error)     kerr_q <= 1'b1;
      else if (bus.clr_err) kerr_q <= 1'b0;
      if (ovf_evt)          ovf_q  <= 1'b1;
      else if (bus.clr_err) ovf_q  <= 1'b0;
    end
  end

  assign bus.rd_valid = ~fifo_empty;
  assign bus.rd_data  = {1'b0, fifo_dout};
  assign bus.overflow = ovf_q;
  assign bus.kbd_err  = kerr_q;
  assign bus.shift_st = shift;
  assign bus.caps_st  = caps;

endmodule
